// File: rtl/eth_tx_drv.sv
// Ethernet MII transmit driver.
// Takes one whole frame as a wide parallel word over valid/ready. Sends it as
// 4-bit nibbles: preamble and SFD first, then the frame, then an optional
// CRC-32 FCS, then a fixed inter-frame gap. The serialiser only advances on
// clk edges where tx_nib_en is high.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready asserted, waiting for a frame
// PREAMBLE | 15 nibbles of 5, then D (SFD 0xD5)
// DATA     | frame nibbles, byte 0 first, low nibble of each byte first
// FCS      | ~crc, least significant nibble first (CRC_EN=1 only)
// IFG      | tx_en low for IFG_NIBBLES strobes; the frame is counted here
module eth_tx_drv #(
   parameter int ETH_MAX_FRAME_SIZE = 256,
   parameter bit CRC_EN             = 1'b1,
   parameter int IFG_NIBBLES        = 24
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ETH_MAX_FRAME_SIZE-1:0] tx_drv_wr_data,
   input  logic                          tx_drv_wr_valid,
   output logic                          tx_drv_wr_ready,
   input  logic                          tx_nib_en,
   output logic [3:0]                    txd,
   output logic                          tx_en,
   output logic                          tx_busy,
   output logic [15:0]                   tx_frame_count
);

   localparam int W         = ETH_MAX_FRAME_SIZE;
   localparam int DATA_NIBS = W / 4;
   localparam int MAX_A     = (DATA_NIBS > 16) ? DATA_NIBS : 16;
   localparam int CNT_MAX   = (IFG_NIBBLES > MAX_A) ? IFG_NIBBLES : MAX_A;
   localparam int CW        = $clog2(CNT_MAX + 1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PRE  = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_FCS  = 3'd3;
   localparam logic [2:0] ST_IFG  = 3'd4;

   localparam logic [CW-1:0] PRE_LAST  = CW'(15);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_NIBS - 1);
   localparam logic [CW-1:0] FCS_LAST  = CW'(7);
   localparam logic [CW-1:0] IFG_LAST  = CW'(IFG_NIBBLES - 1);

   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  shreg;
   logic [31:0]   crc;
   logic [31:0]   crc_next;
   logic [31:0]   fcs;
   logic [3:0]    data_nib;
   logic [3:0]    fcs_nib;

   // Reflected CRC-32, four bit-serial steps, data LSB first
   function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 4; i++) begin
         if (r[0] ^ d[i])
            r = (r >> 1) ^ 32'hEDB8_8320;
         else
            r = r >> 1;
      end
      return r;
   endfunction

   // Current data nibble (the top byte holds the next byte to send), next CRC and FCS nibble
   always_comb begin
      data_nib = cnt[0] ? shreg[W-1 -: 4] : shreg[W-5 -: 4];
      crc_next = crc_nib(crc, data_nib);
      fcs      = ~crc;
      fcs_nib  = fcs[{cnt[2:0], 2'b00} +: 4];
   end

   // Sequencer: state, nibble counter, shift register, CRC and all registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         shreg           <= '0;
         crc             <= CRC_INIT;
         txd             <= 4'h0;
         tx_en           <= 1'b0;
         tx_busy         <= 1'b0;
         tx_drv_wr_ready <= 1'b0;
         tx_frame_count  <= 16'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tx_drv_wr_valid && tx_drv_wr_ready) begin
                  shreg           <= tx_drv_wr_data;
                  state           <= ST_PRE;
                  cnt             <= '0;
                  tx_drv_wr_ready <= 1'b0;
                  tx_busy         <= 1'b1;
               end else begin
                  tx_drv_wr_ready <= 1'b1;
               end
            end
            ST_PRE: begin
               if (tx_nib_en) begin
                  tx_en <= 1'b1;
                  if (cnt == PRE_LAST) begin
                     txd   <= 4'hD;
                     state <= ST_DATA;
                     cnt   <= '0;
                  end else begin
                     txd <= 4'h5;
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            ST_DATA: begin
               if (tx_nib_en) begin
                  txd <= data_nib;
                  crc <= crc_next;
                  // Both nibbles of the top byte are out: bring up the next byte
                  if (cnt[0])
                     shreg <= shreg << 8;
                  if (cnt == DATA_LAST) begin
                     state <= CRC_EN ? ST_FCS : ST_IFG;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            ST_FCS: begin
               if (tx_nib_en) begin
                  txd <= fcs_nib;
                  if (cnt == FCS_LAST) begin
                     state <= ST_IFG;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            ST_IFG: begin
               if (tx_nib_en) begin
                  tx_en <= 1'b0;
                  txd   <= 4'h0;
                  if (cnt == '0)
                     tx_frame_count <= tx_frame_count + 16'd1;
                  if (cnt == IFG_LAST) begin
                     state           <= ST_IDLE;
                     cnt             <= '0;
                     crc             <= CRC_INIT;
                     tx_busy         <= 1'b0;
                     tx_drv_wr_ready <= 1'b1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            default: begin
               state           <= ST_IDLE;
               cnt             <= '0;
               crc             <= CRC_INIT;
               txd             <= 4'h0;
               tx_en           <= 1'b0;
               tx_busy         <= 1'b0;
               tx_drv_wr_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_drv.sv
// Testbench for eth_tx_drv.
// dut_a: 256-bit frame with no FCS. dut_b: 72-bit frame with FCS.
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
module tb_eth_tx_drv;

   localparam int AW = 256;
   localparam int BW = 72;
   localparam int BN = 16 + BW / 4 + 8;   // nibbles per dut_b frame with tx_en high

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [AW-1:0] a_data;
   logic          a_valid, a_ready, a_nib, a_en, a_busy;
   logic [3:0]    a_txd;
   logic [15:0]   a_cnt;

   logic [BW-1:0] b_data;
   logic          b_valid, b_ready, b_nib, b_en, b_busy;
   logic [3:0]    b_txd;
   logic [15:0]   b_cnt;

   eth_tx_drv #(.ETH_MAX_FRAME_SIZE(AW), .CRC_EN(1'b0), .IFG_NIBBLES(24)) dut_a (
      .clk(clk), .rst(rst),
      .tx_drv_wr_data(a_data), .tx_drv_wr_valid(a_valid), .tx_drv_wr_ready(a_ready),
      .tx_nib_en(a_nib), .txd(a_txd), .tx_en(a_en), .tx_busy(a_busy),
      .tx_frame_count(a_cnt)
   );

   eth_tx_drv #(.ETH_MAX_FRAME_SIZE(BW), .CRC_EN(1'b1), .IFG_NIBBLES(24)) dut_b (
      .clk(clk), .rst(rst),
      .tx_drv_wr_data(b_data), .tx_drv_wr_valid(b_valid), .tx_drv_wr_ready(b_ready),
      .tx_nib_en(b_nib), .txd(b_txd), .tx_en(b_en), .tx_busy(b_busy),
      .tx_frame_count(b_cnt)
   );

   typedef struct {
      logic        nib;
      logic [3:0]  txd;
      logic        en;
      logic        busy;
      logic        ready;
      logic [15:0] cnt;
   } vec_t;

   vec_t          tbl[$];
   logic [3:0]    exp_b[BN];
   logic [BW-1:0] msg;
   logic [31:0]   fcs_ref;
   int            nvec = 0;
   int            nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_nib   = 1'b0;
      b_nib   = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic wait_ready_b();
      for (int i = 0; i < 100; i++) begin
         if (b_ready) break;
         tick();
      end
      chk("b_ready_wait", b_ready, 1);
   endtask

   // Checks dut_b's frame nibbles exp_b[from..BN-1], one nibble per clock (tx_nib_en held high)
   task automatic b_stream(input int from);
      for (int k = from; k < BN; k++) begin
         tick();
         chk($sformatf("b_txd[%0d]", k), b_txd, exp_b[k]);
         chk($sformatf("b_en[%0d]", k), b_en, 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  pt;
      logic        pe;
      logic [15:0] pc;
      int          low;

      // Expected wire image of "123456789": preamble, SFD, data, then the known check FCS
      msg     = "123456789";
      fcs_ref = 32'hCBF4_3926;
      for (int i = 0; i < 15; i++) exp_b[i] = 4'h5;
      exp_b[15] = 4'hD;
      for (int j = 0; j < 9; j++) begin
         logic [7:0] by;
         by = msg[BW-1-8*j -: 8];
         exp_b[16+2*j] = by[3:0];
         exp_b[17+2*j] = by[7:4];
      end
      for (int j = 0; j < 8; j++) exp_b[34+j] = fcs_ref[4*j +: 4];

      // Vector table: one strobe every 4th clock; the three clocks between strobes must hold
      pt = 4'h0; pe = 1'b0; pc = 16'd0;
      for (int k = 0; k < BN; k++) begin
         for (int h = 0; h < 3; h++) tbl.push_back('{1'b0, pt, pe, 1'b1, 1'b0, pc});
         tbl.push_back('{1'b1, exp_b[k], 1'b1, 1'b1, 1'b0, pc});
         pt = exp_b[k]; pe = 1'b1;
      end
      for (int k = 0; k < 24; k++) begin
         for (int h = 0; h < 3; h++) tbl.push_back('{1'b0, pt, pe, 1'b1, 1'b0, pc});
         tbl.push_back('{1'b1, 4'h0, 1'b0, (k != 23), (k == 23), 16'd1});
         pt = 4'h0; pe = 1'b0; pc = 16'd1;
      end

      a_data = '0; b_data = '0;
      a_valid = 1'b0; b_valid = 1'b0; a_nib = 1'b0; b_nib = 1'b0;

      // Reset values, applied asynchronously before any clock edge
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      chk("rst_a_ready", a_ready, 0);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_en", a_en, 0);
      chk("rst_a_txd", a_txd, 0);
      chk("rst_a_cnt", a_cnt, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_b_busy", b_busy, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("post_rst_a_ready", a_ready, 1);
      chk("post_rst_b_ready", b_ready, 1);

      // dut_a: every byte A5, no FCS, tx_nib_en high on every clock
      a_data  = {32{8'hA5}};
      a_valid = 1'b1;
      a_nib   = 1'b1;
      tick();
      a_valid = 1'b0;
      chk("a_acc_ready", a_ready, 0);
      chk("a_acc_busy", a_busy, 1);
      chk("a_acc_en", a_en, 0);
      for (int k = 0; k < 80; k++) begin
         logic [3:0] e;
         if (k < 15)                e = 4'h5;
         else if (k == 15)          e = 4'hD;
         else if (((k - 16) % 2) == 0) e = 4'h5;
         else                       e = 4'hA;
         tick();
         chk($sformatf("a_txd[%0d]", k), a_txd, e);
         chk($sformatf("a_en[%0d]", k), a_en, 1);
      end
      for (int k = 0; k < 24; k++) begin
         tick();
         chk($sformatf("a_ifg_en[%0d]", k), a_en, 0);
         chk($sformatf("a_ifg_txd[%0d]", k), a_txd, 0);
         chk($sformatf("a_ifg_cnt[%0d]", k), a_cnt, 1);
         chk($sformatf("a_ifg_ready[%0d]", k), a_ready, (k == 23));
         chk($sformatf("a_ifg_busy[%0d]", k), a_busy, (k != 23));
      end
      a_nib = 1'b0;

      // dut_b: "123456789" with a strobe every 4th clock; data is scrambled right after acceptance
      wait_ready_b();
      b_data  = msg;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      b_data  = '1;
      chk("b_acc_ready", b_ready, 0);
      chk("b_acc_busy", b_busy, 1);
      for (int i = 0; i < tbl.size(); i++) begin
         b_nib = tbl[i].nib;
         tick();
         chk($sformatf("tbl_txd[%0d]", i), b_txd, tbl[i].txd);
         chk($sformatf("tbl_en[%0d]", i), b_en, tbl[i].en);
         chk($sformatf("tbl_busy[%0d]", i), b_busy, tbl[i].busy);
         chk($sformatf("tbl_ready[%0d]", i), b_ready, tbl[i].ready);
         chk($sformatf("tbl_cnt[%0d]", i), b_cnt, tbl[i].cnt);
      end
      b_nib = 1'b0;

      // Back-to-back frames with valid held high; the gap is 24 IFG strobes plus the IDLE acceptance clock
      do_reset();
      b_data  = msg;
      b_valid = 1'b1;
      b_nib   = 1'b1;
      tick();
      chk("b2b_acc_ready", b_ready, 0);
      b_stream(0);
      low = 0;
      while (low < 40) begin
         tick();
         if (b_en) break;
         low++;
      end
      chk("b2b_gap", low, 25);
      chk("b2b_first_pre", b_txd, 5);
      chk("b2b_cnt1", b_cnt, 1);
      b_valid = 1'b0;
      b_stream(1);
      tick();
      chk("b2b_ifg_en", b_en, 0);
      chk("b2b_cnt2", b_cnt, 2);

      // Reset in the middle of DATA, then a clean frame afterwards
      wait_ready_b();
      b_data  = msg;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("mid_en_before", b_en, 1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_en", b_en, 0);
      chk("mid_rst_busy", b_busy, 0);
      chk("mid_rst_txd", b_txd, 0);
      chk("mid_rst_cnt", b_cnt, 0);
      #2 rst = 1'b1;
      tick();
      chk("mid_rel_ready", b_ready, 1);
      chk("mid_rel_en", b_en, 0);
      b_data  = msg;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      b_stream(0);
      tick();
      chk("mid_after_cnt", b_cnt, 1);
      b_nib = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
